// File: rtl/vscale_uart_host.sv
// vscale_uart_host: board/sim-side 8N1 UART endpoint facing vscale_chip.
// Serial bytes are converted to and from byte-wide valid/ready streams. The
// transmitter and receiver run independently, so full duplex and loopback
// (txd_to_chip tied to rxd_from_chip) both work.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   rxd_from_chip           serial in from chip TXD (asynchronous, idle high)
//   txd_to_chip             serial out to chip RXD (idle high)
//   tx_valid/tx_data/tx_ready   byte stream into the transmitter
//   rx_valid/rx_data/rx_ready   byte stream out of the one-entry rx buffer
//   rx_frame_err            one-cycle pulse when a stop bit is sampled low
//   rx_overrun              sticky: a byte was dropped because the buffer was full
module vscale_uart_host #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_from_chip,
    output logic       txd_to_chip,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_sh;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt == LAST);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_valid) tx_next = TX_START;
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_idx <= '0;
                if (tx_valid) tx_sh <= tx_data;
            end else begin
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                if (tx_state == TX_DATA && tx_bit_end) begin
                    tx_sh  <= {1'b0, tx_sh[7:1]};
                    tx_idx <= tx_idx + 3'd1;
                end
            end
        end
    end

    // Line level is decoded from state so that reset forces it high at once.
    assign txd_to_chip = (tx_state == TX_START) ? 1'b0 :
                         (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;
    assign tx_ready    = (tx_state == TX_IDLE);

    // ---------------- receiver ----------------
    logic [1:0] rx_sync;
    logic       rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_sync <= 2'b11;
        else       rx_sync <= {rx_sync[0], rxd_from_chip};
    end
    assign rxs = rx_sync[1];

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_sh;
    logic          rx_done, rx_bad, rx_bit_end;

    assign rx_bit_end = (rx_cnt == LAST);

    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        rx_bad  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rxs) rx_next = RX_START;
            // Half-bit resample: a line back high here was only a glitch.
            RX_START: if (rx_cnt == HALF) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rxs) begin
                        rx_done = 1'b1;
                        rx_next = RX_IDLE;
                    end else begin
                        rx_bad  = 1'b1;
                        rx_next = RX_WAIT_IDLE;
                    end
                end
            end
            // Break or held-low line: wait for idle before hunting a new start.
            RX_WAIT_IDLE: if (rxs) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_next;
            case (rx_state)
                RX_START: rx_cnt <= (rx_cnt == HALF) ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    rx_cnt <= rx_bit_end ? '0 : rx_cnt + 1'b1;
                    if (rx_bit_end) begin
                        rx_sh  <= {rxs, rx_sh[7:1]};
                        rx_idx <= rx_idx + 3'd1;
                    end
                end
                RX_STOP: rx_cnt <= rx_bit_end ? '0 : rx_cnt + 1'b1;
                default: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                end
            endcase
        end
    end

    // One-entry buffer. A delivery may land in the same cycle the consumer
    // drains the old byte; otherwise a full buffer keeps the old byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= rx_bad;
            if (rx_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_sh;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule
